// File: rtl/alu_sequencer.sv
// Operation sequencer for the 4-bit ALU: single-cycle ops finish in one cycle,
// shift-add multiply and restoring divide iterate over ITER cycles.
module alu_sequencer #(
    parameter int WIDTH = 4,
    parameter int ITER  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               carry,
    output logic               zero,
    output logic               lt,
    output logic               eq,
    output logic               gt,
    output logic               err
);

    localparam int W  = WIDTH;
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOTA = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_CMP  = 4'd8,
        OP_MUL  = 4'd9,
        OP_DIV  = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        ITER_ST,
        DONE
    } state_e;

    state_e           state;
    logic [CW-1:0]    cnt;
    logic [2*W-1:0]   acc;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             is_div;

    logic [W:0]       sum5;
    logic [W:0]       diff5;
    logic [2*W-1:0]   alu_res;
    logic             alu_c;
    logic             alu_err;
    logic             is_iter;

    logic [W:0]       mul_sum;
    logic [W:0]       div_trial;
    logic [W:0]       div_diff;
    logic [2*W-1:0]   step_next;

    // Single-cycle datapath, evaluated on the live inputs at acceptance.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
        alu_res = '0;
        alu_c   = 1'b0;
        alu_err = 1'b0;
        sum5    = {1'b0, a} + {1'b0, b};
        diff5   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        is_iter = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = {{W{1'b0}}, sum5[W-1:0]};
                alu_c   = sum5[W];
            end
            OP_SUB: begin
                alu_res = {{W{1'b0}}, diff5[W-1:0]};
                alu_c   = diff5[W];
            end
            OP_AND:  alu_res = {{W{1'b0}}, a & b};
            OP_OR:   alu_res = {{W{1'b0}}, a | b};
            OP_XOR:  alu_res = {{W{1'b0}}, a ^ b};
            OP_NOTA: alu_res = {{W{1'b0}}, ~a};
            OP_SHL: begin
                alu_res = {{W{1'b0}}, a[W-2:0], 1'b0};
                alu_c   = a[W-1];
            end
            OP_SHR: begin
                alu_res = {{W{1'b0}}, 1'b0, a[W-1:1]};
                alu_c   = a[0];
            end
            OP_CMP:  alu_res = '0;
            OP_MUL:  is_iter = 1'b1;
            OP_DIV: begin
                if (b == '0) begin
                    alu_res = {a, {W{1'b1}}};
                    alu_err = 1'b1;
                end else begin
                    is_iter = 1'b1;
                end
            end
            default: alu_err = 1'b1;
        endcase
    end

    // One iteration step. MUL: acc is the product register P.
    // DIV: acc holds {remainder, dividend/quotient shift register}.
    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b_q} : '0);
        div_trial = {acc[2*W-1:W], acc[W-1]};
        div_diff  = div_trial - {1'b0, b_q};
        step_next = '0;
        if (is_div) begin
            if (div_trial >= {1'b0, b_q})
                step_next = {div_diff[W-1:0], acc[W-2:0], 1'b1};
            else
                step_next = {div_trial[W-1:0], acc[W-2:0], 1'b0};
        end else begin
            step_next = {mul_sum, acc[W-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the accumulator and captured operands are cleared too, so an aborted operation leaves no stale state behind.
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            is_div    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            err       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        is_div   <= (op == OP_DIV);
                        in_ready <= 1'b0;
                        if (is_iter) begin
                            acc   <= {{W{1'b0}}, a};
                            cnt   <= '0;
                            state <= ITER_ST;
                        end else begin
                            result    <= alu_res;
                            carry     <= alu_c;
                            zero      <= (alu_res == '0);
                            lt        <= (a < b);
                            eq        <= (a == b);
                            gt        <= (a > b);
                            err       <= alu_err;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                ITER_ST: begin
                    acc <= step_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        result    <= step_next;
                        carry     <= 1'b0;
                        zero      <= (step_next == '0);
                        lt        <= (a_q < b_q);
                        eq        <= (a_q == b_q);
                        gt        <= (a_q > b_q);
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed, table-driven bench for alu_sequencer with hand-computed expectations
// plus stall, busy-window and mid-operation reset sequences.
module tb_alu_sequencer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic       lt;
    logic       eq;
    logic       gt;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    alu_sequencer #(.WIDTH(4), .ITER(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .lt        (lt),
        .eq        (eq),
        .gt        (gt),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags are packed as {carry, zero, lt, eq, gt, err}.
    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] res;
        logic [5:0] flags;
        int         lat;
        int         stall;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs[NVEC];

    function automatic logic [5:0] flags_now();
        return {carry, zero, lt, eq, gt, err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_op(input string tag, input vec_t v);
        int         waitc;
        int         lat;
        logic       busy_bad;
        logic       stall_bad;
        logic [7:0] r0;
        logic [5:0] f0;
        waitc = 0;
        @(negedge clk);
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check({tag, " in_ready before issue"}, 32'(in_ready), 32'd1);
        op       = v.op;
        a        = v.a;
        b        = v.b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 4'($urandom);
        a        = 4'($urandom);
        b        = 4'($urandom);
        lat      = 1;
        busy_bad = in_ready;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            busy_bad = busy_bad | in_ready;
        end
        check({tag, " latency"}, 32'(lat), 32'(v.lat));
        check({tag, " in_ready low while busy"}, 32'(busy_bad), 32'd0);
        check({tag, " result"}, 32'(result), 32'(v.res));
        check({tag, " flags"}, 32'(flags_now()), 32'(v.flags));
        r0        = result;
        f0        = flags_now();
        stall_bad = 1'b0;
        for (int i = 0; i < v.stall; i++) begin
            @(posedge clk);
            #1;
            if (!out_valid || result !== r0 || flags_now() !== f0 || in_ready)
                stall_bad = 1'b1;
        end
        if (v.stall > 0)
            check({tag, " outputs stable while stalled"}, 32'(stall_bad), 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " out_valid drops after handshake"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
        check({tag, " result held in idle"}, 32'(result), 32'(v.res));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        vec_t v;

        vecs[0]  = '{4'd0,  4'hB, 4'h7, 8'h02, 6'b100010, 1, 0};  // ADD carry out
        vecs[1]  = '{4'd1,  4'h3, 4'h5, 8'h0E, 6'b001000, 1, 3};  // SUB borrow, stalled
        vecs[2]  = '{4'd2,  4'hC, 4'hA, 8'h08, 6'b000010, 1, 0};  // AND
        vecs[3]  = '{4'd3,  4'h5, 4'hA, 8'h0F, 6'b001000, 1, 0};  // OR
        vecs[4]  = '{4'd4,  4'h6, 4'h6, 8'h00, 6'b010100, 1, 0};  // XOR -> zero
        vecs[5]  = '{4'd5,  4'h3, 4'h9, 8'h0C, 6'b001000, 1, 0};  // NOTA
        vecs[6]  = '{4'd6,  4'h9, 4'h0, 8'h02, 6'b100010, 1, 0};  // SHL
        vecs[7]  = '{4'd7,  4'h9, 4'h0, 8'h04, 6'b100010, 1, 0};  // SHR
        vecs[8]  = '{4'd8,  4'h6, 4'h6, 8'h00, 6'b010100, 1, 0};  // CMP equal
        vecs[9]  = '{4'd9,  4'hF, 4'hF, 8'hE1, 6'b000100, 5, 0};  // MUL max
        vecs[10] = '{4'd9,  4'h3, 4'h5, 8'h0F, 6'b001000, 5, 0};  // MUL
        vecs[11] = '{4'd9,  4'h0, 4'h7, 8'h00, 6'b011000, 5, 0};  // MUL by zero
        vecs[12] = '{4'd10, 4'hD, 4'h4, 8'h13, 6'b000010, 5, 0};  // DIV 13/4
        vecs[13] = '{4'd10, 4'h9, 4'h0, 8'h9F, 6'b000011, 1, 0};  // DIV by zero
        vecs[14] = '{4'd10, 4'hF, 4'h1, 8'h0F, 6'b000010, 5, 0};  // DIV by one
        vecs[15] = '{4'd10, 4'h2, 4'h7, 8'h20, 6'b001000, 5, 0};  // DIV a<b
        vecs[16] = '{4'd12, 4'h2, 4'h3, 8'h00, 6'b011001, 1, 0};  // illegal op
        vecs[17] = '{4'd15, 4'h8, 4'h1, 8'h00, 6'b010011, 1, 0};  // illegal op
        vecs[18] = '{4'd1,  4'h7, 4'h7, 8'h00, 6'b110100, 1, 0};  // SUB equal
        vecs[19] = '{4'd0,  4'h8, 4'h8, 8'h00, 6'b110100, 1, 0};  // ADD wrap to zero

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        a         = '0;
        b         = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset flags", 32'(flags_now()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready after first edge", 32'(in_ready), 32'd1);

        for (int i = 0; i < NVEC; i++)
            do_op($sformatf("vec%0d", i), vecs[i]);

        // Reset during the MUL iteration aborts it with no result.
        @(negedge clk);
        op       = 4'd9;
        a        = 4'hF;
        b        = 4'hF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid-op reset out_valid", 32'(out_valid), 32'd0);
        check("mid-op reset in_ready", 32'(in_ready), 32'd0);
        check("mid-op reset result", 32'(result), 32'd0);
        check("mid-op reset flags", 32'(flags_now()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid)
                bad = 1'b1;
        end
        check("no result after aborted MUL", 32'(bad), 32'd0);

        v = '{4'd0, 4'h1, 4'h1, 8'h02, 6'b000100, 1, 0};
        do_op("ADD after reset", v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
